// File: rtl/uart_lite.sv
// rtl/uart_lite.sv - 16450-style UART, 8N1, one-byte TX holding register and RX buffer
// Register decode, 16x baud generator, TX/RX state machines and level interrupt.
module uart_lite #(
    parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       we,
    input  logic       re,
    input  logic       ce,
    output logic       txd,
    input  logic       rxd,
    output logic       irq
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic        we_q, wr, dlab, wr_div, tick, rx_done;
    logic [1:0]  ier;
    logic [7:0]  lcr, mcr, scr, dll, dlm, thr, rbr, iir;
    logic        dr, oe, fe, thre, temt;
    logic [15:0] baud_cnt, new_div;
    logic [1:0]  tx_state, rx_state;
    logic [3:0]  tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shift, rx_shift;
    logic        rx_s1, rx_s2;
    logic        unused_inputs;

    assign unused_inputs = ^{re, ce};

    // Counter runs from divisor-1 down to 0 so the tick period equals the divisor.
    function automatic logic [15:0] reload_val(input logic [15:0] d);
        return (d == 16'd0) ? 16'd0 : d - 16'd1;
    endfunction

    assign dlab    = lcr[7];
    assign wr      = we & ~we_q;
    assign wr_div  = wr && dlab && (addr == 3'd0 || addr == 3'd1);
    assign new_div = (addr == 3'd0) ? {dlm, din} : {din, dll};
    assign tick    = (baud_cnt == 16'd0);
    assign rx_done = (rx_state == ST_STOP) && tick && (rx_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (reset)
            baud_cnt <= reload_val(DEFAULT_DIV);
        else if (wr_div)
            baud_cnt <= reload_val(new_div);
        else if (tick)
            baud_cnt <= reload_val({dlm, dll});
        else
            baud_cnt <= baud_cnt - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q <= 1'b0;
            ier  <= 2'd0;
            lcr  <= 8'd0;
            mcr  <= 8'd0;
            scr  <= 8'd0;
            dll  <= DEFAULT_DIV[7:0];
            dlm  <= DEFAULT_DIV[15:8];
            rbr  <= 8'd0;
            dr   <= 1'b0;
            oe   <= 1'b0;
            fe   <= 1'b0;
            irq  <= 1'b0;
        end else begin
            we_q <= we;
            irq  <= (ier[0] & dr) | (ier[1] & thre);
            if (wr) begin
                case (addr)
                    3'd0: if (dlab) dll <= din;
                    3'd1: if (dlab) dlm <= din; else ier <= din[1:0];
                    3'd3: lcr <= din;
                    3'd4: mcr <= din;
                    3'd5: begin dr <= 1'b0; oe <= 1'b0; fe <= 1'b0; end
                    3'd7: scr <= din;
                    default: ;
                endcase
            end
            // Receive completion follows the LSR clear so it wins a same-cycle collision.
            if (rx_done) begin
                rbr <= rx_shift;
                dr  <= 1'b1;
                if (dr)     oe <= 1'b1;
                if (!rx_s2) fe <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            txd      <= 1'b1;
            thre     <= 1'b1;
            temt     <= 1'b1;
            thr      <= 8'd0;
            tx_shift <= 8'd0;
            tx_cnt   <= 4'd0;
            tx_bit   <= 3'd0;
        end else begin
            if (tick) begin
                case (tx_state)
                    ST_IDLE: begin
                        tx_cnt <= 4'd0;
                        if (!thre) begin
                            tx_shift <= thr;
                            thre     <= 1'b1;
                            temt     <= 1'b0;
                            txd      <= 1'b0;
                            tx_state <= ST_START;
                        end
                    end
                    ST_START: begin
                        tx_cnt <= tx_cnt + 4'd1;
                        if (tx_cnt == 4'd15) begin
                            txd      <= tx_shift[0];
                            tx_bit   <= 3'd0;
                            tx_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        tx_cnt <= tx_cnt + 4'd1;
                        if (tx_cnt == 4'd15) begin
                            if (tx_bit == 3'd7) begin
                                txd      <= 1'b1;
                                tx_state <= ST_STOP;
                            end else begin
                                tx_shift <= tx_shift >> 1;
                                txd      <= tx_shift[1];
                                tx_bit   <= tx_bit + 3'd1;
                            end
                        end
                    end
                    default: begin
                        tx_cnt <= tx_cnt + 4'd1;
                        if (tx_cnt == 4'd15) begin
                            if (!thre) begin
                                tx_shift <= thr;
                                thre     <= 1'b1;
                                txd      <= 1'b0;
                                tx_state <= ST_START;
                            end else begin
                                temt     <= 1'b1;
                                tx_state <= ST_IDLE;
                            end
                        end
                    end
                endcase
            end
            // A write colliding with a load leaves the new byte pending (THRE stays 0).
            if (wr && addr == 3'd0 && !dlab) begin
                thr  <= din;
                thre <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= 4'd0;
                    if (!rx_s2) rx_state <= ST_START;
                end
                ST_START: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd7) begin
                        rx_cnt   <= 4'd0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                    end
                end
                default: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15) rx_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign iir = (ier[0] & dr)   ? 8'h04 :
                 (ier[1] & thre) ? 8'h02 : 8'h01;

    always_comb begin
        dout = 8'h00;
        case (addr)
            3'd0: dout = dlab ? dll : rbr;
            3'd1: dout = dlab ? dlm : {6'b0, ier};
            3'd2: dout = iir;
            3'd3: dout = lcr;
            3'd4: dout = mcr;
            3'd5: dout = {1'b0, temt, thre, 2'b0, fe, oe, dr};
            3'd7: dout = scr;
            default: dout = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_uart_lite.sv
// tb/tb_uart_lite.sv - randomized scoreboard bench for uart_lite
// TX frames are decoded by a monitor against a queue of expected bytes; RX uses a status model.
module tb_uart_lite;
    logic       clk = 1'b0;
    logic       reset, we, re, ce, rxd;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       txd, irq;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    logic [7:0] tx_q[$];

    bit         m_dr, m_oe, m_fe;
    logic [7:0] m_rbr;

    uart_lite dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .dout(dout),
        .we(we), .re(re), .ce(ce), .txd(txd), .rxd(rxd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; din = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wr_hold(input logic [2:0] a, input logic [7:0] d, input int n);
        @(negedge clk);
        addr = a; din = d; we = 1'b1;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        #1 d = dout;
        re = 1'b0;
    endtask

    task automatic wait_lsr(input int bitn, input int maxc, input string name);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < maxc; i++) begin
            rd(3'd5, v);
            if (v[bitn]) break;
        end
        chk(name, v[bitn], 1);
    endtask

    // Divisor 1: every bit is 16 clocks.
    task automatic send_rx(input logic [7:0] b, input bit stop);
        for (int s = 0; s < 160; s++) begin
            @(negedge clk);
            rxd = (s < 16) ? 1'b0 : (s < 144) ? b[(s - 16) / 16] : stop;
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic rx_model(input logic [7:0] b, input bit stop);
        if (m_dr) m_oe = 1'b1;
        m_dr  = 1'b1;
        m_rbr = b;
        if (!stop) m_fe = 1'b1;
    endtask

    task automatic rx_check(input string tag);
        logic [7:0] v;
        rd(3'd0, v);
        chk({tag, "_rbr"}, v, m_rbr);
        rd(3'd5, v);
        chk({tag, "_lsr"}, v, {5'b01100, m_fe, m_oe, m_dr});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                logic [7:0] eb, got;
                int         bad;
                logic       e;
                chk("tx_frame_expected", tx_q.size() > 0, 1);
                eb  = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
                got = 8'h00;
                bad = 0;
                for (int s = 0; s < 160; s++) begin
                    if (s > 0) @(negedge clk);
                    e = (s < 16) ? 1'b0 : (s < 144) ? eb[(s - 16) / 16] : 1'b1;
                    if (txd !== e) bad++;
                    if (s >= 16 && s < 144 && (s % 16) == 8) got[(s - 16) / 16] = txd;
                end
                chk("tx_byte", got, eb);
                chk("tx_bit_timing_errors", bad, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v, b;
        bit         stop;
        reset = 1'b1; we = 1'b0; re = 1'b0; ce = 1'b0; rxd = 1'b1; addr = 3'd0; din = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_irq", irq, 0);
        reset = 1'b0;
        rd(3'd5, v); chk("reset_lsr", v, 8'h60);
        rd(3'd2, v); chk("reset_iir", v, 8'h01);
        rd(3'd1, v); chk("reset_ier", v, 8'h00);
        rd(3'd3, v); chk("reset_lcr", v, 8'h00);

        wr(3'd3, 8'h80);
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h00);
        rd(3'd0, v); chk("dll_rb", v, 8'h01);
        rd(3'd3, v); chk("lcr_rb", v, 8'h80);
        wr(3'd3, 8'h00);
        b = 8'($urandom); wr(3'd7, b); rd(3'd7, v); chk("scr_rb", v, b);
        b = 8'($urandom); wr(3'd4, b); rd(3'd4, v); chk("mcr_rb", v, b);
        rd(3'd6, v); chk("addr6_zero", v, 8'h00);

        mon_en = 1'b1;
        tx_q.push_back(8'hA5);
        wr(3'd0, 8'hA5);
        rd(3'd5, v); chk("lsr_after_load", v, 8'h20);
        wait_lsr(6, 300, "temt_a5");
        rd(3'd5, v); chk("lsr_after_a5", v, 8'h60);

        tx_q.push_back(8'h3C);
        wr_hold(3'd0, 8'h3C, 5);
        wait_lsr(6, 300, "temt_3c");
        repeat (40) @(negedge clk);
        chk("tx_q_empty_3c", tx_q.size(), 0);

        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            wait_lsr(5, 400, "thre_wait");
            repeat ($urandom_range(0, 30)) @(negedge clk);
            tx_q.push_back(b);
            wr(3'd0, b);
        end
        wait_lsr(6, 1500, "temt_random");
        repeat (10) @(negedge clk);
        chk("tx_q_empty_random", tx_q.size(), 0);

        wr(3'd1, 8'h01);
        wr(3'd5, 8'h00);
        m_dr = 0; m_oe = 0; m_fe = 0; m_rbr = 8'h00;
        send_rx(8'h5A, 1'b1); rx_model(8'h5A, 1'b1);
        rx_check("rx_5a");
        rd(3'd2, v); chk("iir_rx", v, 8'h04);
        chk("irq_rx", irq, 1);
        wr(3'd5, 8'h00); m_dr = 0; m_oe = 0; m_fe = 0;
        repeat (2) @(negedge clk);
        chk("irq_cleared", irq, 0);
        rd(3'd5, v); chk("lsr_cleared", v, 8'h60);

        send_rx(8'h11, 1'b1); rx_model(8'h11, 1'b1);
        send_rx(8'h22, 1'b1); rx_model(8'h22, 1'b1);
        rx_check("rx_overrun");
        send_rx(8'h96, 1'b0); rx_model(8'h96, 1'b0);
        rx_check("rx_frame_err");

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                wr(3'd5, 8'h00);
                m_dr = 0; m_oe = 0; m_fe = 0;
            end
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_rx(b, stop); rx_model(b, stop);
            rx_check("rx_random");
        end

        wr(3'd5, 8'h00); m_dr = 0; m_oe = 0; m_fe = 0;
        @(negedge clk); rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        rd(3'd5, v); chk("glitch_no_dr", v, 8'h60);
        send_rx(8'hC3, 1'b1); rx_model(8'hC3, 1'b1);
        rx_check("rx_after_glitch");

        wr(3'd1, 8'h02);
        repeat (2) @(negedge clk);
        rd(3'd2, v); chk("iir_thre", v, 8'h02);
        chk("irq_thre", irq, 1);
        wr(3'd1, 8'h00);

        mon_en = 1'b0;
        wr(3'd0, 8'($urandom));
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("txd_after_reset", txd, 1);
        @(negedge clk);
        reset = 1'b0;
        rd(3'd5, v); chk("lsr_after_reset", v, 8'h60);
        repeat (2) @(negedge clk);
        chk("irq_after_reset", irq, 0);
        wr(3'd3, 8'h80);
        rd(3'd0, v); chk("dll_default", v, 8'd27);
        rd(3'd1, v); chk("dlm_default", v, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
